// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM: drives fetch-stage enables and the imem req/ready handshake.
// Define FETCH_PERF_CNT_EN to build the saturating StallCount counter; otherwise StallCount is 0.
module fetch_sequencer #(
   parameter int MAX_WAIT    = 15,
   parameter int BOOT_CYCLES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Halt,
   input  logic             Redirect,
   input  logic             LoadUseHazard,
   input  logic             ImemReady,
   output logic             ImemReq,
   output logic             EN,
   output logic             RetainPC,
   output logic             RetainIF_ID,
   output logic             IF_Flush,
   output logic             Busy,
   output logic             TimeoutErr,
   output logic [CNT_W-1:0] StallCount
);

   // state      | meaning
   // S_IDLE     | out of reset, waiting for Start
   // S_BOOT     | flushing IF/ID for BOOT_CYCLES cycles
   // S_FETCH    | issuing one request per cycle
   // S_WAIT_MEM | request outstanding, memory not ready
   // S_STALL    | load-use hazard, PC and IF/ID held
   // S_FLUSH    | bubble after a redirect cancelled an outstanding request
   // S_HALTED   | stopped, waiting for Start
   // S_ERROR    | memory timeout, left only through Reset
   typedef enum logic [2:0] {
      S_IDLE,
      S_BOOT,
      S_FETCH,
      S_WAIT_MEM,
      S_STALL,
      S_FLUSH,
      S_HALTED,
      S_ERROR
   } state_t;

   localparam logic [3:0] BOOT_LOAD = 4'(BOOT_CYCLES - 1);
   localparam logic [7:0] WAIT_LOAD = 8'(MAX_WAIT - 1);

   state_t     state;
   logic [3:0] boot_tmr;
   logic [7:0] wait_tmr;
   logic       halt_pend;
   logic       timeout_err;

   // Both timers count down and fire at zero, so the load value is the cycle budget minus one.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state       <= S_IDLE;
         boot_tmr    <= '0;
         wait_tmr    <= '0;
         halt_pend   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (Start) begin
                  state    <= S_BOOT;
                  boot_tmr <= BOOT_LOAD;
               end
            end
            S_BOOT: begin
               if (boot_tmr == 4'd0) state <= S_FETCH;
               else                  boot_tmr <= boot_tmr - 4'd1;
            end
            S_FETCH: begin
               if (Halt)               state <= S_HALTED;
               else if (Redirect)      state <= S_FETCH;
               else if (LoadUseHazard) state <= S_STALL;
               else if (!ImemReady) begin
                  state    <= S_WAIT_MEM;
                  wait_tmr <= WAIT_LOAD;
               end
            end
            S_WAIT_MEM: begin
               if (Halt) halt_pend <= 1'b1;
               if (Redirect)       state <= S_FLUSH;
               else if (ImemReady) state <= (halt_pend || Halt) ? S_HALTED : S_FETCH;
               else if (wait_tmr == 8'd0) begin
                  state       <= S_ERROR;
                  timeout_err <= 1'b1;
               end else begin
                  wait_tmr <= wait_tmr - 8'd1;
               end
            end
            S_STALL: begin
               if (Redirect)           state <= S_FETCH;
               else if (Halt)          state <= S_HALTED;
               else if (!LoadUseHazard) state <= S_FETCH;
            end
            S_FLUSH: state <= S_FETCH;
            S_HALTED: begin
               if (Start && !Halt) begin
                  state     <= S_FETCH;
                  halt_pend <= 1'b0;
               end
            end
            default: state <= S_ERROR;
         endcase
      end
   end

   always_comb begin
      ImemReq     = 1'b0;
      EN          = 1'b0;
      RetainPC    = 1'b1;
      RetainIF_ID = 1'b1;
      IF_Flush    = 1'b0;
      case (state)
         S_BOOT: begin
            EN       = 1'b1;
            IF_Flush = 1'b1;
         end
         S_FETCH: begin
            EN      = 1'b1;
            ImemReq = 1'b1;
            if (Halt) begin
               ImemReq = 1'b0;
            end else if (Redirect) begin
               IF_Flush = 1'b1;
               RetainPC = 1'b0;
            end else if (!LoadUseHazard && ImemReady) begin
               RetainPC    = 1'b0;
               RetainIF_ID = 1'b0;
            end
         end
         S_WAIT_MEM: begin
            EN      = 1'b1;
            ImemReq = 1'b1;
            if (Redirect) begin
               IF_Flush = 1'b1;
               RetainPC = 1'b0;
            end else if (ImemReady) begin
               RetainPC    = 1'b0;
               RetainIF_ID = 1'b0;
            end
         end
         S_STALL: begin
            EN = 1'b1;
            if (Redirect) begin
               IF_Flush = 1'b1;
               RetainPC = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign Busy       = (state == S_BOOT) || (state == S_FETCH) || (state == S_WAIT_MEM) ||
                       (state == S_STALL) || (state == S_FLUSH);
   assign TimeoutErr = timeout_err;

`ifdef FETCH_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         stall_cnt <= '0;
      end else if ((state == S_STALL || state == S_WAIT_MEM) && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign StallCount = stall_cnt;
`else
   assign StallCount = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random stimulus
// compared every cycle against a behavioural model of the fetch controller.
module tb_fetch_sequencer;
   localparam int MAX_WAIT    = 15;
   localparam int BOOT_CYCLES = 2;
   localparam int CNT_W       = 6;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic CLK = 1'b0;
   logic Reset = 1'b1;
   logic Start = 1'b0, Halt = 1'b0, Redirect = 1'b0, LoadUseHazard = 1'b0, ImemReady = 1'b0;
   logic ImemReq, EN, RetainPC, RetainIF_ID, IF_Flush, Busy, TimeoutErr;
   logic [CNT_W-1:0] StallCount;

   fetch_sequencer #(.MAX_WAIT(MAX_WAIT), .BOOT_CYCLES(BOOT_CYCLES), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .Reset(Reset), .Start(Start), .Halt(Halt), .Redirect(Redirect),
      .LoadUseHazard(LoadUseHazard), .ImemReady(ImemReady), .ImemReq(ImemReq), .EN(EN),
      .RetainPC(RetainPC), .RetainIF_ID(RetainIF_ID), .IF_Flush(IF_Flush), .Busy(Busy),
      .TimeoutErr(TimeoutErr), .StallCount(StallCount)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int passes = 0;

   typedef enum {M_IDLE, M_BOOT, M_FETCH, M_WAIT, M_STALL, M_FLUSH, M_HALTED, M_ERROR} mph_t;
   mph_t ph;
   int   boot_left, waited, stalls;
   bit   hp, err;

`ifdef FETCH_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
   endtask

   // {ImemReq, EN, RetainPC, RetainIF_ID, IF_Flush}
   function automatic logic [4:0] exp_ctrl();
      logic req, en, rpc, rif, fl;
      req = 0; en = 0; rpc = 1; rif = 1; fl = 0;
      case (ph)
         M_BOOT: begin en = 1; fl = 1; end
         M_FETCH: begin
            en = 1; req = 1;
            if (Halt) req = 0;
            else if (Redirect) begin fl = 1; rpc = 0; end
            else if (LoadUseHazard) begin end
            else if (ImemReady) begin rpc = 0; rif = 0; end
         end
         M_WAIT: begin
            en = 1; req = 1;
            if (Redirect) begin fl = 1; rpc = 0; end
            else if (ImemReady) begin rpc = 0; rif = 0; end
         end
         M_STALL: begin
            en = 1;
            if (Redirect) begin fl = 1; rpc = 0; end
         end
         default: ;
      endcase
      return {req, en, rpc, rif, fl};
   endfunction

   function automatic int exp_count();
      return PERF ? stalls : 0;
   endfunction

   task automatic model_reset();
      ph = M_IDLE; boot_left = 0; waited = 0; stalls = 0; hp = 0; err = 0;
   endtask

   task automatic model_step();
      bit h;
      if ((ph == M_WAIT || ph == M_STALL) && stalls < CNT_MAX) stalls++;
      case (ph)
         M_IDLE: if (Start) begin ph = M_BOOT; boot_left = BOOT_CYCLES; end
         M_BOOT: begin boot_left--; if (boot_left == 0) ph = M_FETCH; end
         M_FETCH: begin
            if (Halt) ph = M_HALTED;
            else if (Redirect) ph = M_FETCH;
            else if (LoadUseHazard) ph = M_STALL;
            else if (!ImemReady) begin ph = M_WAIT; waited = 1; end
         end
         M_WAIT: begin
            h = hp || Halt;
            if (Halt) hp = 1;
            if (Redirect) ph = M_FLUSH;
            else if (ImemReady) ph = h ? M_HALTED : M_FETCH;
            else if (waited == MAX_WAIT) begin ph = M_ERROR; err = 1; end
            else waited++;
         end
         M_STALL: begin
            if (Redirect) ph = M_FETCH;
            else if (Halt) ph = M_HALTED;
            else if (!LoadUseHazard) ph = M_FETCH;
         end
         M_FLUSH: ph = M_FETCH;
         M_HALTED: if (Start && !Halt) begin ph = M_FETCH; hp = 0; end
         default: ;
      endcase
   endtask

   task automatic compare_model();
      logic exp_busy;
      exp_busy = (ph == M_BOOT || ph == M_FETCH || ph == M_WAIT || ph == M_STALL || ph == M_FLUSH);
      check("ctrl", 32'({ImemReq, EN, RetainPC, RetainIF_ID, IF_Flush}), 32'(exp_ctrl()));
      check("busy_timeout", 32'({Busy, TimeoutErr}), 32'({exp_busy, err}));
      check("stall_count", 32'(StallCount), 32'(exp_count()));
   endtask

   task automatic drive(input logic st, input logic hl, input logic rd, input logic lu,
                        input logic rdy);
      @(negedge CLK);
      Start = st; Halt = hl; Redirect = rd; LoadUseHazard = lu; ImemReady = rdy;
      #1;
      compare_model();
   endtask

   task automatic step();
      @(posedge CLK);
      model_step();
   endtask

   task automatic cyc(input logic st, input logic hl, input logic rd, input logic lu,
                      input logic rdy);
      drive(st, hl, rd, lu, rdy);
      step();
   endtask

   task automatic do_reset();
      @(negedge CLK);
      Reset = 1'b1;
      #1;
      model_reset();
      compare_model();
      check("rst_ctrl", 32'({ImemReq, EN, RetainPC, RetainIF_ID, IF_Flush}), 32'(5'b00110));
      check("rst_busy_timeout", 32'({Busy, TimeoutErr}), 32'(2'b00));
      check("rst_stall_count", 32'(StallCount), 32'd0);
      Start = 0; Halt = 0; Redirect = 0; LoadUseHazard = 0; ImemReady = 0;
      @(negedge CLK);
      Reset = 1'b0;
   endtask

   initial begin
      bit slow;
      model_reset();
      do_reset();

      // Boot: two flush cycles, then one instruction per cycle
      drive(1, 0, 0, 0, 1); check("idle_no_flush", 32'(IF_Flush), 32'd0); step();
      drive(0, 0, 0, 0, 1); check("boot1_flush", 32'(IF_Flush), 32'd1); step();
      drive(0, 0, 0, 0, 1); check("boot2_flush", 32'(IF_Flush), 32'd1); step();
      drive(0, 0, 0, 0, 1);
      check("fetch_advance", 32'({ImemReq, RetainPC, RetainIF_ID, IF_Flush}), 32'(4'b1000));
      step();
      cyc(0, 0, 0, 0, 1);

      // Three wait cycles then advance
      drive(0, 0, 0, 0, 0); check("miss_retain", 32'({ImemReq, RetainPC, RetainIF_ID}), 32'(3'b111)); step();
      drive(0, 0, 0, 0, 0); check("wait1_req", 32'({ImemReq, RetainPC, RetainIF_ID}), 32'(3'b111)); step();
      drive(0, 0, 0, 0, 0); check("wait2_req", 32'({ImemReq, RetainPC, RetainIF_ID}), 32'(3'b111)); step();
      drive(0, 0, 0, 0, 1); check("wait3_advance", 32'({RetainPC, RetainIF_ID}), 32'(2'b00)); step();
      drive(0, 0, 0, 0, 1); check("stall_count_3", 32'(StallCount), PERF ? 32'd3 : 32'd0); step();

      // Load-use stall, redirect in the second cycle
      drive(0, 0, 0, 1, 1); check("lu_retain", 32'({RetainPC, RetainIF_ID, IF_Flush}), 32'(3'b110)); step();
      drive(0, 0, 1, 1, 1); check("stall_redirect", 32'({RetainPC, RetainIF_ID, IF_Flush}), 32'(3'b011)); step();
      drive(0, 0, 0, 0, 1); check("post_stall_fetch", 32'(ImemReq), 32'd1); step();

      // Redirect during WAIT_MEM gives one request-free bubble
      cyc(0, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0); check("wait_redirect", 32'({IF_Flush, RetainPC}), 32'(2'b10)); step();
      drive(0, 0, 0, 0, 1); check("flush_bubble", 32'({ImemReq, Busy}), 32'(2'b01)); step();
      drive(0, 0, 0, 0, 1); check("flush_resume", 32'({ImemReq, RetainPC}), 32'(2'b10)); step();

      // Halt while waiting: the outstanding fetch completes, then HALTED
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1); check("halt_pend_advance", 32'(RetainIF_ID), 32'd0); step();
      drive(0, 0, 0, 0, 0); check("halted_idle", 32'({Busy, ImemReq}), 32'(2'b00)); step();
      cyc(1, 0, 0, 0, 1);
      drive(0, 0, 0, 0, 1); check("restart_fetch", 32'({Busy, ImemReq}), 32'(2'b11)); step();

      // Timeout after MAX_WAIT waiting cycles
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < MAX_WAIT - 1; i++) cyc(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0); check("last_wait_busy", 32'(Busy), 32'd1); step();
      drive(0, 0, 0, 0, 0); check("timeout_set", 32'({TimeoutErr, Busy}), 32'(2'b10)); step();
      drive(1, 0, 0, 0, 1); check("timeout_sticky", 32'({TimeoutErr, ImemReq}), 32'(2'b10)); step();
      do_reset();

      // Reset mid-wait
      cyc(1, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0); check("mid_wait_req", 32'(ImemReq), 32'd1); step();
      do_reset();

      // Random traffic
      slow = 0;
      for (int i = 0; i < 6000; i++) begin
         if ((err && ($urandom % 4 == 0)) || ($urandom % 500 == 0)) begin
            do_reset();
         end else begin
            logic rdy;
            if ($urandom % 40 == 0) slow = !slow;
            rdy = slow ? 1'b0 : ($urandom % 10 < 6);
            cyc(($urandom % 3) == 0, ($urandom % 20) == 0, ($urandom % 7) == 0,
                ($urandom % 6) == 0, rdy);
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control FSM for the instruction-fetch stage. It drives the fetch-stage controls EN, RetainPC, RetainIF_ID and IF_Flush, and runs a req/ready handshake with a variable-latency instruction memory. It arbitrates between four sources: redirects from the decode stage (jump/branch), load-use stalls, halt requests and memory wait states. It sits between the hazard unit and the fetch stage.

Parameters:
MAX_WAIT, 15, max consecutive WAIT_MEM cycles before timeout; legal range 1..255.
BOOT_CYCLES, 2, IF/ID flush cycles after Start; legal range 1..15.
CNT_W, 16, width of StallCount.

Ports:
CLK  in  1  clock
Reset  in  1  async active-high reset
Start  in  1  level; leave IDLE/HALTED and begin fetching
Halt  in  1  level; stop fetching at the next legal point
Redirect  in  1  taken jump/jalr/branch resolved in ID this cycle
LoadUseHazard  in  1  ID-stage load-use hazard; hold PC and IF/ID
ImemReady  in  1  instruction memory has valid data for the current request
ImemReq  out  1  fetch request to instruction memory
EN  out  1  fetch-stage enable
RetainPC  out  1  hold PC
RetainIF_ID  out  1  hold IF/ID register
IF_Flush  out  1  zero IF/ID register
Busy  out  1  state is BOOT, FETCH, WAIT_MEM, STALL or FLUSH
TimeoutErr  out  1  sticky memory-timeout flag
StallCount  out  CNT_W  stalled-cycle counter

Behaviour:
- Reset (async, asserted at any time, including mid-WAIT_MEM):
  - state IDLE, all counters 0.
  - Outputs: ImemReq=0, EN=0, RetainPC=1, RetainIF_ID=1, IF_Flush=0, Busy=0, TimeoutErr=0, StallCount=0.
- Outputs are Mealy, decoded from state plus inputs. Default outside the active cases below: EN=0, ImemReq=0, RetainPC=1, RetainIF_ID=1, IF_Flush=0.
- IDLE: Start -> BOOT with boot_cnt=0.
- BOOT: EN=1, IF_Flush=1, RetainPC=1. boot_cnt increments; at boot_cnt==BOOT_CYCLES-1 -> FETCH.
- FETCH: ImemReq=1, EN=1. Priority, highest first:
  1. Halt -> HALTED. Retain both, no request issued.
  2. Redirect -> IF_Flush=1, RetainPC=0 (PC loads target), RetainIF_ID=1; stay FETCH.
  3. LoadUseHazard -> retain both; -> STALL.
  4. ImemReady -> RetainPC=0, RetainIF_ID=0 (advance 1 instr/cycle); stay FETCH.
  5. Otherwise -> retain both; -> WAIT_MEM with wait_cnt=1.
- WAIT_MEM: ImemReq=1 held, EN=1, retain both.
  - Redirect -> IF_Flush=1, RetainPC=0; -> FLUSH (request dropped).
  - Else ImemReady -> advance as in FETCH; -> HALTED if halt_pend, else FETCH.
  - Else wait_cnt==MAX_WAIT -> ERROR.
  - Else wait_cnt++.
  - Halt seen here sets halt_pend; the in-flight fetch is never abandoned for Halt.
- STALL: EN=1, retain both.
  - Redirect -> flush as in FETCH; -> FETCH.
  - Else Halt -> HALTED.
  - Else !LoadUseHazard -> FETCH (no advance this cycle).
- FLUSH: one bubble cycle with ImemReq=0, so the cancelled request is dropped; -> FETCH. A Redirect here is ignored.
- HALTED: all defaults. Start && !Halt -> FETCH; halt_pend cleared.
- ERROR: TimeoutErr=1 (set on entry, sticky); all defaults; exit only via Reset.
- Simultaneous events:
  - Redirect beats LoadUseHazard and ImemReady in the same cycle; the fetched instruction is discarded.
  - Halt beats Redirect in FETCH only.
- StallCount: +1 each cycle in STALL or WAIT_MEM; saturates at all-ones (no wrap).

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: StallCount as specified.
- Undefined: counter logic removed, StallCount tied to 0.
- All other behaviour identical in both builds.

Test Plan:
- Reset, Start=1 with BOOT_CYCLES=2 -> IF_Flush=1 for exactly 2 cycles, then FETCH. ImemReady=1 steady -> RetainPC=0, RetainIF_ID=0 every cycle.
- ImemReady low 3 cycles then high -> WAIT_MEM for 3 cycles with ImemReq held and both retains=1. Advance on the 4th cycle; StallCount=3.
- LoadUseHazard high 2 cycles with Redirect=1 in the second -> first cycle retains both. Second cycle IF_Flush=1, RetainPC=0, -> FETCH.
- Redirect during WAIT_MEM -> IF_Flush=1 that cycle, ImemReq=0 next cycle (FLUSH), fetch resumes the cycle after.
- Halt during WAIT_MEM, ImemReady 2 cycles later -> one advance, then HALTED with Busy=0. Start -> FETCH.
- ImemReady never asserted, MAX_WAIT=15 -> ERROR after 15 WAIT_MEM cycles, TimeoutErr=1 until Reset. Reset asserted mid-wait instead -> all outputs return to reset values immediately.
